addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op  input  1  1 = add, 0 = subtract (A - B, two's complement).
REQ-007 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b  SHALL mirror REQ-004..REQ-007 for requester 1.
REQ-009 rsp_valid  output  1  registered result available.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_r  output  32  result bits [31:0].
REQ-013 rsp_carry  output  1  carry-out of the add; 0 for subtract.

Function
REQ-014 Block SHALL contain exactly one 32-bit add/sub datapath, shared by both requesters.
REQ-015 Two states: EMPTY (no result held), FULL (result held, rsp_valid = 1).
REQ-016 Slot free this cycle = EMPTY, or FULL with rsp_ready = 1.
REQ-017 When slot free and at least one reqN_valid, exactly one requester SHALL be granted: reqN_ready = 1 for the winner only.
REQ-018 When slot not free, req0_ready = req1_ready = 0.
REQ-019 reqN_ready SHALL be combinational from the valids, rsp_ready, state and priority pointer; never from operand values.
REQ-020 Arbitration round-robin: 1-bit pointer names the preferred requester; if both valid, preferred wins; if one valid, it wins regardless of pointer.
REQ-021 After a grant, pointer SHALL update to the non-granted index; pointer unchanged when no grant.
REQ-022 On grant: rsp_r <= A + B (op=1) or A - B mod 2^32 (op=0); rsp_carry <= bit 32 of A + B (op=1) or 0 (op=0); rsp_id <= winner; state <= FULL next cycle.
REQ-023 Latency: grant in cycle N -> rsp_valid = 1 in cycle N+1 with result.
REQ-024 FULL with rsp_ready = 0: rsp_valid, rsp_r, rsp_carry and rsp_id SHALL hold stable.
REQ-025 FULL with rsp_ready = 1 and a grant: new result loaded; rsp_valid stays 1 (sustained throughput one op per cycle).
REQ-026 FULL with rsp_ready = 1 and no valid request: state <= EMPTY, rsp_valid = 0 next cycle.
REQ-027 rsp_ready while EMPTY SHALL be ignored.
REQ-028 Overflow not flagged; arithmetic wraps modulo 2^32.
REQ-029 A requester that drops valid without ready SHALL lose no state; fairness pointer is not affected.

Reset
REQ-030 reset = 1 at a clock edge: state <= EMPTY, pointer <= 0 (requester 0 preferred), rsp_r <= 0, rsp_carry <= 0, rsp_id <= 0.
REQ-031 While reset = 1, req0_ready = req1_ready = 0 and rsp_valid = 0; reset overrides any grant in the same cycle, and a held result is discarded.

Verification
REQ-032 Reset, then req0 add A=0xFFFFFFFF B=0x00000001, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_r=0x00000000, rsp_carry=1.
REQ-033 req1 subtract A=5 B=7 -> rsp_r=0xFFFFFFFE, rsp_carry=0, rsp_id=1.
REQ-034 Both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1 with one result per cycle.
REQ-035 Result held with rsp_ready=0 for 3 cycles while both request -> both readys 0, rsp_* stable; on rsp_ready=1 the preferred requester is granted in that same cycle.
REQ-036 Assert reset while FULL with rsp_ready=0 -> next cycle rsp_valid=0, pointer=0; first later simultaneous request granted to requester 0.

Source files
------------

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters share one 32-bit add/sub datapath.
// A round-robin arbiter grants one requester per cycle into a single
// registered result slot, which drains through a valid/ready response port.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. reqN_ready depends only on the valids, rsp_ready, state and the
// priority pointer, never on operand values. rsp_* stay stable while
// rsp_valid = 1 and rsp_ready = 0.
module addsub_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_r,
    output logic        rsp_carry
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state;
    state_t      state_next;
    logic        ptr;
    logic        slot_free;
    logic        grant0;
    logic        grant1;
    logic        grant_any;
    logic        sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [31:0] b_eff;
    logic [32:0] sum;

    // Slot can take a new result when empty or when the held one leaves now;
    // reset blocks every grant in its cycle.
    assign slot_free = !reset && ((state == EMPTY) || rsp_ready);

    // Round-robin: the pointer only matters when both requesters are valid.
    assign grant0    = slot_free && req0_valid && (!req1_valid || !ptr);
    assign grant1    = slot_free && req1_valid && (!req0_valid ||  ptr);
    assign grant_any = grant0 || grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state == FULL) && !reset;

    // Shared datapath: subtract is A + ~B + 1; carry is reported for add only.
    assign sel_op = grant1 ? req1_op : req0_op;
    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;
    assign b_eff  = sel_op ? sel_b : ~sel_b;
    assign sum    = {1'b0, sel_a} + {1'b0, b_eff} + {32'b0, ~sel_op};

    // Next-state logic for the result slot.
    always_comb begin
        state_next = state;
        if (grant_any) begin
            state_next = FULL;
        end else if ((state == FULL) && rsp_ready) begin
            state_next = EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Priority pointer moves to the loser after each grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (grant0) begin
            ptr <= 1'b1;
        end else if (grant1) begin
            ptr <= 1'b0;
        end
    end

    // Result registers load on a grant and otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_r     <= 32'd0;
            rsp_carry <= 1'b0;
            rsp_id    <= 1'b0;
        end else if (grant_any) begin
            rsp_r     <= sum[31:0];
            rsp_carry <= sel_op & sum[32];
            rsp_id    <= grant1;
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed per-cycle vectors with hand-computed
// results; a negedge monitor compares the response port against a queue.
module tb_addsub_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_carry;
    logic [31:0] rsp_r;

    logic [33:0] exp_q[$];   // {id, carry, r}
    int          checks   = 0;
    int          failures = 0;
    logic        started  = 1'b0;

    addsub_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_r(rsp_r), .rsp_carry(rsp_carry)
    );

    // Clock.
    always #5 clk = ~clk;

    // Timeout guard.
    initial begin
        #200000;
        $display("FAIL timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%h req=%h t=%0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus. g: 0 = no grant, 1 = req0, 2 = req1.
    task automatic cyc(input logic rst,
                       input logic v0, input logic op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic op1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic rdy, input int g, input logic [31:0] er, input logic ec);
        reset = rst;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp_ready = rdy;
        if (rst) exp_q.delete();
        @(negedge clk);
        check("req0_ready", {33'b0, req0_ready}, {33'b0, g == 1});
        check("req1_ready", {33'b0, req1_ready}, {33'b0, g == 2});
        @(posedge clk);
        if (g != 0) exp_q.push_back({g == 2, ec, er});
        #1;
    endtask

    // Monitor: response must match the queue head; pops on handshake.
    always @(negedge clk) begin
        if (started) begin
            if (exp_q.size() != 0) begin
                check("rsp_valid", {33'b0, rsp_valid}, 34'd1);
                check("rsp_data", {rsp_id, rsp_carry, rsp_r}, exp_q[0]);
                if (rsp_ready) void'(exp_q.pop_front());
            end else begin
                check("rsp_valid_idle", {33'b0, rsp_valid}, 34'd0);
            end
        end
    end

    initial begin
        reset = 1'b1;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        rsp_ready = 0;
        @(posedge clk); @(posedge clk); #1;
        started = 1'b1;

        // Reset with both requesting: no grants, reset values on rsp.
        cyc(1, 1,1,32'h1,32'h1, 1,1,32'h2,32'h2, 1, 0, 32'h0, 0);
        check("reset_rsp", {rsp_id, rsp_carry, rsp_r}, 34'd0);

        // Add with carry-out, then subtract with borrow, then drain.
        cyc(0, 1,1,32'hFFFFFFFF,32'h00000001, 0,0,32'h0,32'h0, 1, 1, 32'h00000000, 1);
        cyc(0, 0,0,32'h0,32'h0, 1,0,32'd5,32'd7, 1, 2, 32'hFFFFFFFE, 0);
        cyc(0, 1,0,32'h0,32'h1, 0,0,32'h0,32'h0, 1, 1, 32'hFFFFFFFF, 0);
        cyc(0, 0,0,32'h0,32'h0, 1,1,32'h12345678,32'h87654321, 1, 2, 32'h99999999, 0);
        cyc(0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 1, 0, 32'h0, 0);
        cyc(0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 1, 0, 32'h0, 0);

        // Both valid after reset: grants alternate 0,1,0,1 back to back.
        cyc(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                cyc(0, 1,1,32'h80000000,32'h80000001, 1,0,32'd3,32'd3, 1, 1, 32'h00000001, 1);
            else
                cyc(0, 1,1,32'h80000000,32'h80000001, 1,0,32'd3,32'd3, 1, 2, 32'h00000000, 0);
        end

        // Result held 3 cycles with both requesting; then req0 (preferred) wins.
        for (int i = 0; i < 3; i++)
            cyc(0, 1,1,32'd10,32'd20, 1,0,32'd50,32'd8, 0, 0, 32'h0, 0);
        cyc(0, 1,1,32'd10,32'd20, 1,0,32'd50,32'd8, 1, 1, 32'd30, 0);

        // Reset while FULL and stalled: result discarded, pointer back to 0.
        cyc(0, 1,1,32'd10,32'd20, 1,0,32'd50,32'd8, 0, 0, 32'h0, 0);
        cyc(1, 1,1,32'd10,32'd20, 1,0,32'd50,32'd8, 0, 0, 32'h0, 0);
        cyc(0, 1,1,32'd10,32'd20, 1,0,32'd50,32'd8, 0, 1, 32'd30, 0);
        cyc(0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 1, 0, 32'h0, 0);
        cyc(0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 1, 0, 32'h0, 0);

        check("queue_drained", 34'(exp_q.size()), 34'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
